// File: rtl/uart_pkg.sv
// Shared definitions for the bus-attached UART transmitter.
//   - Register offsets inside the 16-byte register window
//   - STATUS register bit positions
//   - Serializer state encoding
package uart_pkg;

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_DIV    = 4'h8;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_CNT_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/bus_if.sv
// Simple single-cycle request bus shared between the arbiter and slaves.
//   req/addr/we/be/wdata : request, driven by the master side
//   gnt                  : grant, driven by the slave side
//   rdata/rvalid/err     : response, one cycle after a granted request
interface bus_if;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;

  modport master (output req, addr, we, be, wdata, input gnt, rdata, rvalid, err);
  modport slave  (input req, addr, we, be, wdata, output gnt, rdata, rvalid, err);
endinterface

// File: rtl/fifo_sync.sv
// Single-clock FIFO with fill count.
//   clk_i, rst_ni : clock, asynchronous active-low reset (pointers/count only)
//   push, wdata   : write request and data; accepted when not full, or when
//                   full and a pop happens in the same cycle
//   pop, rdata    : pop request; rdata always shows the head entry
//   full, empty   : occupancy flags
//   count         : number of stored entries
module fifo_sync #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // When full, a concurrent pop frees the slot the write lands in.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bus_uart_tx.sv
// Bus-attached UART transmitter (8N1) with TX FIFO.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : slave port; zero-wait grant, response one cycle after request
//            0x0 TXDATA (W), 0x4 STATUS (R), 0x8 DIV (R/W, 16 bit)
//   tx_o   : serial line, idle high
//   irq_o  : high while FIFO empty and serializer idle
module bus_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0002_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic clk_i,
  input  logic rst_ni,
  bus_if.slave bus,
  output logic tx_o,
  output logic irq_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Window selection happens in the arbiter; only the low nibble is decoded.
  logic unused_bits;
  assign unused_bits = ^{bus.addr[31:4], bus.wdata[31:16], bus.be[3:2], BASE_ADDR[3:0]};

  logic [3:0]    off;
  logic          hit_tx, hit_stat, hit_div, bad_addr;
  logic          wr_tx, drop;
  logic          push, pop, full, empty;
  logic [CW-1:0] count;
  logic [7:0]    head;
  logic [15:0]   div_q;
  logic [31:0]   status;
  logic [31:0]   rdata_d;
  logic          err_d;
  logic          vld_p1, err_p1;
  logic [31:0]   rdata_p1;

  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d, period_m1;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        tx_q, tx_d;
  logic        bit_end, busy;

  assign off      = bus.addr[3:0];
  assign hit_tx   = (off == OFF_TXDATA);
  assign hit_stat = (off == OFF_STATUS);
  assign hit_div  = (off == OFF_DIV);
  // Covers 0xC and every offset with addr[1:0] != 0.
  assign bad_addr = !(hit_tx || hit_stat || hit_div);

  assign wr_tx = bus.req && bus.we && hit_tx && bus.be[0];
  assign push  = wr_tx;
  assign drop  = wr_tx && full && !pop;
  assign err_d = bus.req && (bad_addr || drop);

  fifo_sync #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (push),
    .wdata (bus.wdata[7:0]),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign busy  = (state_q != ST_IDLE);
  assign irq_o = empty && !busy;

  always_comb begin
    status                                = '0;
    status[STAT_BUSY]                     = busy;
    status[STAT_FULL]                     = full;
    status[STAT_EMPTY]                    = empty;
    status[STAT_CNT_LSB +: STAT_CNT_W]    = STAT_CNT_W'(count);
  end

  always_comb begin
    rdata_d = '0;
    if (bus.req && !bus.we) begin
      if (hit_stat)     rdata_d = status;
      else if (hit_div) rdata_d = {16'h0000, div_q};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= DEFAULT_DIV;
    end else if (bus.req && bus.we && hit_div) begin
      if (bus.be[0]) div_q[7:0]  <= bus.wdata[7:0];
      if (bus.be[1]) div_q[15:8] <= bus.wdata[15:8];
    end
  end

  assign bus.gnt = bus.req;

  // ---- response stage p1: one cycle after the granted request ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
      err_p1   <= 1'b0;
    end else begin
      vld_p1   <= bus.req;
      rdata_p1 <= rdata_d;
      err_p1   <= err_d;
    end
  end

  assign bus.rvalid = vld_p1;
  assign bus.rdata  = rdata_p1;
  assign bus.err    = err_p1;

  // Divider is sampled only when a bit starts, so a DIV write never
  // stretches or shortens the bit currently on the line.
  assign period_m1 = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;
  assign bit_end   = (baud_q == 16'd0);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    if (state_q != ST_IDLE && !bit_end) baud_d = baud_q - 16'd1;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = head;
          bit_d   = 3'd0;
          baud_d  = period_m1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          baud_d  = period_m1;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          baud_d = period_m1;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = {1'b0, sh_q[7:1]};
          end
        end
      end
      ST_STOP: begin
        if (bit_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = sh_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // ---- serializer stage: line level registered alongside state ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge clk_i) begin
    sh_q <= sh_d;
  end

  assign tx_o = tx_q;

endmodule

// File: doc/bus_uart_tx.md
BUS_UART_TX -- requirements
Module: bus_uart_tx

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0002_0000, byte address of register window (16-byte aligned).
REQ-002 Parameter FIFO_DEPTH, default 8, TX FIFO entries (power of two, 2..16).
REQ-003 Parameter DEFAULT_DIV, default 16'd434, reset value of baud divider (clk cycles per bit).
REQ-004 Clock and reset shall be as follows: one clock; reset is asynchronous and active-low.
REQ-005 clk_i  input  1  clock, all state on rising edge.
REQ-006 rst_ni  input  1  asynchronous active-low reset.
REQ-007 bus  bus_if.slave  -  req/gnt/addr/we/be/wdata/rdata/rvalid/err, fed by the 2-master arbiter.
REQ-008 tx_o  output  1  UART serial line, idle high.
REQ-009 irq_o  output  1  level interrupt, high while FIFO empty and serializer idle.

Function
REQ-010 gnt shall equal req combinationally (zero wait states); addr[31:4] is not decoded (the arbiter does that).
REQ-011 rvalid shall pulse exactly one cycle after each granted cycle, for reads and writes; rdata/err are valid only with rvalid, else 0.
REQ-012 Offset 0x0 TXDATA: write with be[0]=1 pushes wdata[7:0]; reads return 0.
REQ-013 Write to TXDATA while FIFO full shall drop the byte and return err=1.
REQ-014 Offset 0x4 STATUS (read-only): bit0 busy, bit1 full, bit2 empty, bits[8:4] fill count, others 0; writes ignored, err=0.
REQ-015 Offset 0x8 DIV: bits[15:0] read/write, write honours be[1:0] per byte; bits[31:16] read 0.
REQ-016 Offset 0xC and unaligned addr[1:0]!=0 shall return err=1, rdata=0, no side effects.
REQ-017 Serializer FSM states IDLE, START, DATA, STOP.
REQ-018 IDLE: tx_o=1; if FIFO non-empty, pop head, load shift register, go START next cycle.
REQ-019 START: tx_o=0 for one bit period; DATA: 8 bits LSB first, one bit period each; STOP: tx_o=1 one bit period, then IDLE.
REQ-020 Bit period = DIV cycles; DIV=0 treated as 1.
REQ-021 DIV write takes effect at the next bit boundary; current bit unaffected.
REQ-022 Back-to-back bytes: STOP->IDLE->START costs one extra idle cycle, no more.
REQ-023 Simultaneous push and pop in one cycle shall keep count unchanged and never lose data, including when full.
REQ-024 busy = state != IDLE.
REQ-025 FIFO pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.

Reset
REQ-026 On rst_ni low: FIFO empty, state IDLE, DIV=DEFAULT_DIV, tx_o=1, rvalid=0, rdata=0, err=0, irq_o=1.
REQ-027 Reset mid-frame shall abort the frame immediately, tx_o=1, queued bytes discarded.

Structure
REQ-028 Package uart_pkg shall hold register offsets, STATUS bit indices and the FSM state enum.
REQ-029 FIFO shall be a separate sub-module fifo_sync (parameterised DEPTH, WIDTH, push/pop/full/empty/count).

Verification
REQ-030 Reset, read 0x4 -> rdata=32'h0000_0004, read 0x8 -> 32'd434, tx_o=1, irq_o=1.
REQ-031 DIV=4, write TXDATA 8'hA5 -> tx_o: 0,1,0,1,0,0,1,0,1,1 each held 4 cycles; irq_o low during frame.
REQ-032 DIV=100, write 9 bytes back-to-back -> first 9 writes err=0 (one popped), 10th err=1; STATUS full=1, count=8.
REQ-033 Read 0xC and write 0x2 -> err=1, rvalid one cycle after gnt, no state change.
REQ-034 DIV=2, push 2 bytes -> second start bit begins exactly 21 cycles after first start bit.
REQ-035 Assert rst_ni low during DATA bit 3 -> tx_o=1 same cycle, STATUS empty=1 after release.
